// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM states, port ids, read tag.
// Imported by mem_arbiter and mem_arb_tag_pipe.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_I = 2'b01,
    ST_GNT_D = 2'b10
  } st_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// RD_LAT-deep {valid,owner} shift register tracking SRAM reads.
// Synchronous active-low clear drops every in-flight tag.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++)
        r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int k = 1; k < RD_LAT; k++)
        r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter onto one SRAM with read-tag return routing.
// Define MEM_ARB_RR_EN for round-robin ties (default: D wins ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rden,
  input  logic          i_wren,
  input  logic [AW-1:0] i_rd_addr,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic          i_rvalid,
  input  logic          d_rden,
  input  logic          d_wren,
  input  logic [AW-1:0] d_rd_addr,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          m_rden,
  output logic          m_wren,
  output logic [AW-1:0] m_rd_addr,
  output logic [AW-1:0] m_wr_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit PREEMPT = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_TOP =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  st_e           r_st;
  st_e           w_st_nxt;
  logic [HW-1:0] r_hold;
  logic          w_req_i;
  logic          w_req_d;
  logic          w_tie_d;
  logic          w_hold_top;
  rd_tag_t       w_tag_in;
  rd_tag_t       w_tag_out;

  assign w_req_i    = i_rden | i_wren;
  assign w_req_d    = d_rden | d_wren;
  assign w_hold_top = PREEMPT && (r_hold == HOLD_TOP);

`ifdef MEM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst)
      r_last <= PORT_I;
    else if (w_st_nxt != r_st && w_st_nxt != ST_IDLE)
      r_last <= (w_st_nxt == ST_GNT_D) ? PORT_D : PORT_I;
  end

  assign w_tie_d = (r_last == PORT_I);
`else
  assign w_tie_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st   <= ST_IDLE;
      r_hold <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_st_nxt != r_st)
        r_hold <= '0;
      else if (r_st != ST_IDLE && PREEMPT && !w_hold_top)
        r_hold <= r_hold + 1'b1;
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      ST_IDLE: begin
        if (w_req_i && w_req_d)
          w_st_nxt = w_tie_d ? ST_GNT_D : ST_GNT_I;
        else if (w_req_d)
          w_st_nxt = ST_GNT_D;
        else if (w_req_i)
          w_st_nxt = ST_GNT_I;
      end
      ST_GNT_I: begin
        if (!w_req_i)
          w_st_nxt = w_req_d ? ST_GNT_D : ST_IDLE;
        else if (w_req_d && w_hold_top)
          w_st_nxt = ST_GNT_D;
      end
      ST_GNT_D: begin
        if (!w_req_d)
          w_st_nxt = w_req_i ? ST_GNT_I : ST_IDLE;
        else if (w_req_i && w_hold_top)
          w_st_nxt = ST_GNT_I;
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  assign i_gnt = (r_st == ST_GNT_I);
  assign d_gnt = (r_st == ST_GNT_D);

  always_comb begin
    m_rden    = 1'b0;
    m_wren    = 1'b0;
    m_rd_addr = '0;
    m_wr_addr = '0;
    m_wdata   = '0;
    unique case (1'b1)
      i_gnt: begin
        m_rden    = i_rden;
        m_wren    = i_wren;
        m_rd_addr = i_rd_addr;
        m_wr_addr = i_wr_addr;
        m_wdata   = i_wdata;
      end
      d_gnt: begin
        m_rden    = d_rden;
        m_wren    = d_wren;
        m_rd_addr = d_rd_addr;
        m_wr_addr = d_wr_addr;
        m_wdata   = d_wdata;
      end
      default: ;
    endcase
  end

  // Tag the read with its issuer so the data returns there after a switch
  assign w_tag_in.valid = m_rden;
  assign w_tag_in.owner = d_gnt ? PORT_D : PORT_I;

  mem_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign i_rvalid = w_tag_out.valid && (w_tag_out.owner == PORT_I);
  assign d_rvalid = w_tag_out.valid && (w_tag_out.owner == PORT_D);
  assign rdata    = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with an SRAM model.
// Tie expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam logic PI = 1'b0;
  localparam logic PD = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rden, i_wren, d_rden, d_wren;
  logic [15:0] i_rd_addr, i_wr_addr, d_rd_addr, d_wr_addr;
  logic [31:0] i_wdata, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] rdata;
  logic        m_rden, m_wren;
  logic [15:0] m_rd_addr, m_wr_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:16383];

  int checks   = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_rden    (i_rden),
    .i_wren    (i_wren),
    .i_rd_addr (i_rd_addr),
    .i_wr_addr (i_wr_addr),
    .i_wdata   (i_wdata),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .d_rden    (d_rden),
    .d_wren    (d_wren),
    .d_rd_addr (d_rd_addr),
    .d_wr_addr (d_wr_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .rdata     (rdata),
    .m_rden    (m_rden),
    .m_wren    (m_wren),
    .m_rd_addr (m_rd_addr),
    .m_wr_addr (m_wr_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata)
  );

  always #5 clk = ~clk;

  // SRAM with one cycle read latency
  always @(posedge clk) begin
    if (m_wren) mem[m_wr_addr[15:2]] <= m_wdata;
    if (m_rden) m_rdata <= mem[m_rd_addr[15:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic exp_own, prev_v, prev_own, last_tb, win_d;
  int   cnt;

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = '0;
    mem[14'h0101] = 32'hDEADBEEF;
    m_rdata = '0;
    rst = 1'b0;
    i_rden = 0; i_wren = 0; d_rden = 0; d_wren = 0;
    i_rd_addr = 0; i_wr_addr = 0; i_wdata = 0;
    d_rd_addr = 0; d_wr_addr = 0; d_wdata = 0;

    // 1: reset
    repeat (4) tick();
    chk("rst_ignt", i_gnt, 0);
    chk("rst_dgnt", d_gnt, 0);
    chk("rst_irv", i_rvalid, 0);
    chk("rst_drv", d_rvalid, 0);
    chk("rst_mrden", m_rden, 0);
    chk("rst_mwren", m_wren, 0);
    rst = 1'b1;
    tick();

    // 2: icache read
    i_rden = 1; i_rd_addr = 16'h0404;
    #1;
    chk("t2_idle_gnt", i_gnt, 0);
    chk("t2_idle_mrden", m_rden, 0);
    chk("t2_idle_addr", m_rd_addr, 0);
    tick();
    chk("t2_ignt", i_gnt, 1);
    chk("t2_mrden", m_rden, 1);
    chk("t2_maddr", m_rd_addr, 32'h0404);
    tick();
    chk("t2_irv", i_rvalid, 1);
    chk("t2_drv", d_rvalid, 0);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    i_rden = 0;
    tick();
    chk("t2_rel", i_gnt, 0);
    chk("t2_irv_off", i_rvalid, 0);

    // 3: tie, D write wins, then direct switch to I
    i_rden = 1; i_rd_addr = 16'h0404;
    d_wren = 1; d_wr_addr = 16'h1000; d_wdata = 32'h22222222;
    tick();
    chk("t3_dgnt", d_gnt, 1);
    chk("t3_ignt", i_gnt, 0);
    chk("t3_mwren", m_wren, 1);
    chk("t3_mrden", m_rden, 0);
    chk("t3_mwaddr", m_wr_addr, 32'h1000);
    chk("t3_mwdata", m_wdata, 32'h22222222);
    tick();
    d_wren = 0;
    #1;
    chk("t3_mem", mem[14'h0400], 32'h22222222);
    tick();
    chk("t3_sw_ignt", i_gnt, 1);
    chk("t3_sw_dgnt", d_gnt, 0);
    tick();
    chk("t3_irv", i_rvalid, 1);
    chk("t3_rdata", rdata, 32'hDEADBEEF);
    i_rden = 0;
    tick();
    chk("t3_idle", i_gnt | d_gnt, 0);

    // 4: both reading continuously, alternate every 8 grants
    i_rden = 1; i_rd_addr = 16'h0404;
    d_rden = 1; d_rd_addr = 16'h1000;
    exp_own = PD; cnt = 0; prev_v = 0; prev_own = PI;
    for (int c = 0; c < 24; c++) begin
      tick();
      chk("t4_ignt", i_gnt, exp_own == PI);
      chk("t4_dgnt", d_gnt, exp_own == PD);
      chk("t4_irv", i_rvalid, prev_v && prev_own == PI);
      chk("t4_drv", d_rvalid, prev_v && prev_own == PD);
      if (prev_v)
        chk("t4_rdata", rdata,
            (prev_own == PD) ? 32'h22222222 : 32'hDEADBEEF);
      prev_v = 1; prev_own = exp_own;
      if (cnt == 7) begin
        exp_own = ~exp_own;
        cnt = 0;
      end else begin
        cnt++;
      end
    end

    // 6: reset while D owns with a read in flight
    chk("t6_pre_dgnt", d_gnt, 1);
    chk("t6_pre_mrden", m_rden, 1);
    rst = 1'b0;
    tick();
    chk("t6_dgnt", d_gnt, 0);
    chk("t6_ignt", i_gnt, 0);
    chk("t6_drv", d_rvalid, 0);
    chk("t6_irv", i_rvalid, 0);
    chk("t6_mrden", m_rden, 0);
    i_rden = 0; d_rden = 0;
    tick();
    chk("t6_drv2", d_rvalid, 0);
    rst = 1'b1;
    tick();

    // 5: three ties from IDLE after reset
    last_tb = PI;
    for (int k = 0; k < 3; k++) begin
      i_rden = 1; d_rden = 1;
      tick();
`ifdef MEM_ARB_RR_EN
      win_d = (last_tb == PI);
`else
      win_d = 1'b1;
`endif
      chk("t5_dgnt", d_gnt, win_d);
      chk("t5_ignt", i_gnt, !win_d);
      last_tb = win_d ? PD : PI;
      i_rden = 0; d_rden = 0;
      tick();
      chk("t5_idle", i_gnt | d_gnt, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
